// File: rtl/fp_norm_pkg.sv
// ---------------------------------------------------------------------------
// fp_norm_pkg
// Shared types for the FP adder normalise/round pipeline.
//   rmode_e        : rounding mode encoding carried with each beat
//   fp_flags_t     : exception flags {overflow, underflow, inexact, zero}
//   s1_payload_t   : normalised beat held between the normalise and round
//                    stages (sized for the FP_EXP_W / FP_MAN_W widths below)
//   round_increment: decides whether the rounded mantissa gets +1 ulp
// ---------------------------------------------------------------------------
package fp_norm_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } rmode_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
    logic zero;
  } fp_flags_t;

  // Exponent is kept two bits wider and signed so that a left shift past
  // zero or a post-round carry never wraps before the range checks.
  typedef struct packed {
    logic                       sign;
    logic signed [FP_EXP_W+1:0] exp;
    logic [FP_MAN_W:0]          mant;
    logic                       g;
    logic                       r;
    logic                       s;
    rmode_e                     rmode;
    logic                       zero;
  } s1_payload_t;

  function automatic logic round_increment(input rmode_e mode, input logic sign,
                                           input logic g, input logic r,
                                           input logic s, input logic lsb);
    logic lost;
    lost = g | r | s;
    case (mode)
      RNE:     return g & (r | s | lsb);
      RTZ:     return 1'b0;
      RUP:     return !sign & lost;
      RDN:     return sign & lost;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// ---------------------------------------------------------------------------
// fp_lzc
// Combinational leading-zero counter.
//   in_vec : N-bit input vector
//   count  : number of zeros above the most significant set bit;
//            returns N when the input is all zero
// ---------------------------------------------------------------------------
module fp_lzc #(
  parameter int N = 24
) (
  input  logic [N-1:0]           in_vec,
  output logic [$clog2(N+1)-1:0] count
);

  localparam int CW = $clog2(N+1);

  // Scan upward so the highest set bit is the last one to write count.
  always_comb begin
    count = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (in_vec[i]) count = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_round_pipe.sv
// ---------------------------------------------------------------------------
// fp_normalize_round_pipe
// Two-stage normalise-and-round unit for the FP adder datapath.
// Stage 1 normalises the add result (right shift on carry, left shift by the
// leading-zero count otherwise) keeping G/R/S intact; stage 2 rounds,
// renormalises, handles overflow/underflow/zero and registers the result.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   in_valid / in_ready           : input handshake
//   in_sign, in_exp, in_mant,
//   in_carry, in_guard, in_round,
//   in_sticky, in_rmode           : post-add beat and its rounding mode
//   out_valid / out_ready         : output handshake
//   out_sign, out_exp, out_mant   : packed rounded result (hidden bit dropped)
//   out_flags                     : {overflow, underflow, inexact, zero}
// The stage payload type is sized from fp_norm_pkg, so EXP_W/MAN_W must match
// the package widths.
// ---------------------------------------------------------------------------
module fp_normalize_round_pipe
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W:0]   in_mant,
  input  logic             in_carry,
  input  logic             in_guard,
  input  logic             in_round,
  input  logic             in_sticky,
  input  logic [1:0]       in_rmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_mant,
  output logic [3:0]       out_flags
);

  localparam int EW2 = EXP_W + 2;
  localparam int MW  = MAN_W + 1;
  localparam int SW  = MAN_W + 3;
  localparam int MSW = MAN_W + 2;
  localparam int LZW = $clog2(MW + 1);

  localparam logic signed [EW2-1:0] EXP_OVF = EW2'((2 ** EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_MIN = EW2'(1);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  s1_payload_t       s1_q, s1_d;
  s1_payload_t       norm;
  logic              out_sign_q, out_sign_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [MAN_W-1:0]  out_mant_q, out_mant_d;
  fp_flags_t         out_flags_q, out_flags_d;

  logic              s2_load, s1_adv, accept;
  logic [LZW-1:0]    lz_count;
  logic [SW-1:0]     shift_vec;

  logic              inc, grs, ovf, unf, to_inf;
  logic [MSW-1:0]    mant_sum;
  logic [MAN_W:0]    mant_rnd;
  logic signed [EW2-1:0] exp_rnd;
  logic              res_sign;
  logic [EXP_W-1:0]  res_exp;
  logic [MAN_W-1:0]  res_mant;
  fp_flags_t         res_flags;

  fp_lzc #(.N(MW)) u_lzc (
    .in_vec (in_mant),
    .count  (lz_count)
  );

  // Handshake: a stage loads when empty or when its content moves on.
  always_comb begin
    s2_load    = !s2_valid_q | out_ready;
    s1_adv     = s1_valid_q & s2_load;
    in_ready   = !s1_valid_q | s1_adv;
    accept     = in_valid & in_ready;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
  end

  // Normalise. On the left-shift path guard and round ride along below the
  // mantissa so they land in the fraction; an all-zero mantissa shifts by
  // the full width and promotes guard/round into the top bits.
  always_comb begin
    shift_vec  = {in_mant, in_guard, in_round} << lz_count;
    norm.sign  = in_sign;
    norm.rmode = rmode_e'(in_rmode);
    norm.zero  = !in_carry && (in_mant == '0) && !in_guard && !in_round && !in_sticky;
    if (in_carry) begin
      norm.mant = {1'b1, in_mant[MAN_W:1]};
      norm.g    = in_mant[0];
      norm.r    = in_guard;
      norm.s    = in_round | in_sticky;
      norm.exp  = {2'b00, in_exp} + EW2'(1);
    end else begin
      norm.mant = shift_vec[SW-1:2];
      norm.g    = shift_vec[1];
      norm.r    = shift_vec[0];
      norm.s    = in_sticky;
      norm.exp  = {2'b00, in_exp} - EW2'(lz_count);
    end
    s1_d = accept ? norm : s1_q;
  end

  // Round, then fold a carry out of the mantissa back into the exponent.
  always_comb begin
    grs      = s1_q.g | s1_q.r | s1_q.s;
    inc      = round_increment(s1_q.rmode, s1_q.sign, s1_q.g, s1_q.r, s1_q.s, s1_q.mant[0]);
    mant_sum = {1'b0, s1_q.mant} + MSW'(inc);
    if (mant_sum[MSW-1]) begin
      mant_rnd = {1'b1, {MAN_W{1'b0}}};
      exp_rnd  = s1_q.exp + EW2'(1);
    end else begin
      mant_rnd = mant_sum[MAN_W:0];
      exp_rnd  = s1_q.exp;
    end
    ovf    = exp_rnd >= EXP_OVF;
    unf    = exp_rnd < EXP_MIN;
    to_inf = (s1_q.rmode == RNE) || (s1_q.rmode == RUP && !s1_q.sign) ||
             (s1_q.rmode == RDN && s1_q.sign);
  end

  // Exception selection: exact zero wins, then overflow, then underflow.
  always_comb begin
    res_sign          = s1_q.sign;
    res_exp           = exp_rnd[EXP_W-1:0];
    res_mant          = mant_rnd[MAN_W-1:0];
    res_flags         = '0;
    res_flags.inexact = grs;
    if (s1_q.zero) begin
      res_exp        = '0;
      res_mant       = '0;
      res_flags      = '0;
      res_flags.zero = 1'b1;
    end else if (ovf) begin
      res_flags.overflow = 1'b1;
      res_flags.inexact  = 1'b1;
      if (to_inf) begin
        res_exp  = '1;
        res_mant = '0;
      end else begin
        res_exp  = {{(EXP_W-1){1'b1}}, 1'b0};
        res_mant = '1;
      end
    end else if (unf) begin
      res_exp             = '0;
      res_mant            = '0;
      res_flags.underflow = 1'b1;
      res_flags.inexact   = 1'b1;
    end
  end

  always_comb begin
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_mant_d  = out_mant_q;
    out_flags_d = out_flags_q;
    if (s1_adv) begin
      out_sign_d  = res_sign;
      out_exp_d   = res_exp;
      out_mant_d  = res_mant;
      out_flags_d = res_flags;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_mant_q  <= '0;
      out_flags_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s1_q        <= s1_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_mant_q  <= out_mant_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_mant  = out_mant_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_normalize_round_pipe
// Table of hand-derived beats (EXP_W=8, MAN_W=23) streamed through the pipe;
// expected results queue up on each accepted beat and are popped when the
// unit hands a result downstream. Hand-written sequences cover stalls and
// reset in the middle of a stall.
// ---------------------------------------------------------------------------
module tb_fp_normalize_round_pipe;

  typedef struct {
    int          id;
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        carry;
    logic        g;
    logic        r;
    logic        s;
    logic [1:0]  rmode;
    logic [7:0]  e_exp;
    logic [22:0] e_mant;
    logic [3:0]  e_flags;
  } vec_t;

  localparam int NVEC = 27;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [23:0] in_mant = '0;
  logic        in_carry = 1'b0;
  logic        in_guard = 1'b0;
  logic        in_round = 1'b0;
  logic        in_sticky = 1'b0;
  logic [1:0]  in_rmode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_mant;
  logic [3:0]  out_flags;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t tbl[NVEC];
  vec_t exp_q[$];
  vec_t cur;
  logic bp_done;

  always #5 clk = ~clk;

  fp_normalize_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_carry  (in_carry),
    .in_guard  (in_guard),
    .in_round  (in_round),
    .in_sticky (in_sticky),
    .in_rmode  (in_rmode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_flags (out_flags)
  );

  function automatic vec_t mk(input logic sg, input logic [7:0] e, input logic [23:0] m,
                              input logic c, input logic g, input logic r, input logic s,
                              input logic [1:0] rm, input logic [7:0] ee,
                              input logic [22:0] em, input logic [3:0] ef);
    vec_t v;
    v.id = 0; v.sign = sg; v.exp = e; v.mant = m; v.carry = c;
    v.g = g; v.r = r; v.s = s; v.rmode = rm;
    v.e_exp = ee; v.e_mant = em; v.e_flags = ef;
    return v;
  endfunction

  function automatic void checkVal(input string name, input logic [63:0] act,
                                   input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endfunction

  // Flags are {overflow, underflow, inexact, zero}; rmode 0 RNE 1 RTZ 2 RUP 3 RDN.
  task automatic fillTable();
    tbl[0]  = mk(0, 8'h80, 24'h800001, 1, 1, 0, 0, 0, 8'h81, 23'h400001, 4'h2);
    tbl[1]  = mk(0, 8'h90, 24'h000100, 0, 0, 0, 0, 0, 8'h81, 23'h000000, 4'h0);
    tbl[2]  = mk(0, 8'h90, 24'h000100, 0, 1, 0, 0, 0, 8'h81, 23'h004000, 4'h0);
    tbl[3]  = mk(0, 8'h80, 24'h800000, 0, 1, 0, 0, 0, 8'h80, 23'h000000, 4'h2);
    tbl[4]  = mk(0, 8'h80, 24'h800001, 0, 1, 0, 0, 0, 8'h80, 23'h000002, 4'h2);
    tbl[5]  = mk(0, 8'h7F, 24'hFFFFFF, 0, 1, 0, 1, 0, 8'h80, 23'h000000, 4'h2);
    tbl[6]  = mk(0, 8'hFE, 24'hFFFFFF, 0, 1, 0, 1, 0, 8'hFF, 23'h000000, 4'hA);
    tbl[7]  = mk(0, 8'hFE, 24'hFFFFFF, 0, 1, 0, 1, 1, 8'hFE, 23'h7FFFFF, 4'h2);
    tbl[8]  = mk(0, 8'h10, 24'h000001, 0, 0, 0, 0, 0, 8'h00, 23'h000000, 4'h6);
    tbl[9]  = mk(1, 8'h55, 24'h000000, 0, 0, 0, 0, 0, 8'h00, 23'h000000, 4'h1);
    tbl[10] = mk(0, 8'h80, 24'h800000, 0, 0, 0, 1, 2, 8'h80, 23'h000001, 4'h2);
    tbl[11] = mk(1, 8'h80, 24'h800000, 0, 0, 0, 1, 2, 8'h80, 23'h000000, 4'h2);
    tbl[12] = mk(1, 8'h80, 24'h800000, 0, 0, 0, 1, 3, 8'h80, 23'h000001, 4'h2);
    tbl[13] = mk(0, 8'h80, 24'h800000, 0, 0, 0, 1, 3, 8'h80, 23'h000000, 4'h2);
    tbl[14] = mk(1, 8'hFE, 24'hFFFFFF, 1, 0, 0, 0, 1, 8'hFE, 23'h7FFFFF, 4'hA);
    tbl[15] = mk(1, 8'hFF, 24'h800000, 0, 0, 0, 0, 2, 8'hFE, 23'h7FFFFF, 4'hA);
    tbl[16] = mk(1, 8'hFF, 24'h800000, 0, 0, 0, 0, 3, 8'hFF, 23'h000000, 4'hA);
    tbl[17] = mk(0, 8'h3F, 24'hC00000, 0, 0, 0, 0, 0, 8'h3F, 23'h400000, 4'h0);
    tbl[18] = mk(0, 8'h20, 24'h000000, 0, 1, 0, 0, 0, 8'h08, 23'h000000, 4'h0);
    tbl[19] = mk(0, 8'h80, 24'h800000, 0, 1, 1, 0, 0, 8'h80, 23'h000001, 4'h2);
    tbl[20] = mk(0, 8'h80, 24'h400000, 0, 0, 1, 0, 0, 8'h7F, 23'h000000, 4'h2);
    tbl[21] = mk(0, 8'h80, 24'h400000, 0, 0, 1, 1, 0, 8'h7F, 23'h000001, 4'h2);
    tbl[22] = mk(0, 8'h80, 24'h400000, 0, 1, 1, 0, 0, 8'h7F, 23'h000002, 4'h2);
    tbl[23] = mk(0, 8'h01, 24'h800000, 0, 0, 0, 0, 0, 8'h01, 23'h000000, 4'h0);
    tbl[24] = mk(0, 8'h00, 24'h800000, 0, 0, 0, 0, 0, 8'h00, 23'h000000, 4'h6);
    tbl[25] = mk(0, 8'hFE, 24'h800000, 0, 0, 0, 0, 0, 8'hFE, 23'h000000, 4'h0);
    tbl[26] = mk(0, 8'hFF, 24'h800000, 0, 0, 0, 0, 2, 8'hFF, 23'h000000, 4'hA);
    foreach (tbl[i]) tbl[i].id = i;
  endtask

  // Drive one beat and hold it until the unit takes it.
  task automatic applyStimulus(input vec_t v);
    int   waited;
    logic took;
    cur       = v;
    in_sign   = v.sign;
    in_exp    = v.exp;
    in_mant   = v.mant;
    in_carry  = v.carry;
    in_guard  = v.g;
    in_round  = v.r;
    in_sticky = v.s;
    in_rmode  = v.rmode;
    in_valid  = 1'b1;
    waited    = 0;
    took      = 1'b0;
    while (!took && waited < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!took) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout beat%0d: in_ready stayed 0, required 1", v.id);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    e = exp_q.pop_front();
    checkVal($sformatf("beat%0d {sign,exp,mant,flags}", e.id),
             {28'd0, out_sign, out_exp, out_mant, out_flags},
             {28'd0, e.sign, e.e_exp, e.e_mant, e.e_flags});
  endtask

  task automatic waitDrain(input string name);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    checkVal(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: record accepted beats, compare every result handed off and
  // require a stalled result to match the oldest outstanding beat.
  always @(negedge clk) begin
    if (reset_n) begin
      if (in_valid && in_ready) exp_q.push_back(cur);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_output: out_valid=1 with no beat outstanding, required 0");
        end else if (out_ready) begin
          checkOutput();
        end else begin
          checkVal($sformatf("stall_hold beat%0d", exp_q[0].id),
                   {28'd0, out_sign, out_exp, out_mant, out_flags},
                   {28'd0, exp_q[0].sign, exp_q[0].e_exp, exp_q[0].e_mant, exp_q[0].e_flags});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    fillTable();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("reset out_valid", 64'(out_valid), 64'd0);
    checkVal("reset out_sign", 64'(out_sign), 64'd0);
    checkVal("reset out_exp", 64'(out_exp), 64'd0);
    checkVal("reset out_mant", 64'(out_mant), 64'd0);
    checkVal("reset out_flags", 64'(out_flags), 64'd0);
    checkVal("reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] pass 1: streaming table with out_ready held high");
    for (int i = 0; i < NVEC; i++) applyStimulus(tbl[i]);
    waitDrain("drain pass1");

    $display("[TB] pass 2: streaming table with random backpressure");
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < NVEC; i++) applyStimulus(tbl[i]);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    waitDrain("drain pass2");

    $display("[TB] stall: three back-to-back beats with out_ready low");
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(tbl[i]);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        checkVal("stall in_ready", 64'(in_ready), 64'd0);
        checkVal("stall accepted", 64'(exp_q.size()), 64'd2);
        checkVal("stall out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("drain stall");

    $display("[TB] reset in the middle of a stall");
    out_ready = 1'b0;
    applyStimulus(tbl[3]);
    applyStimulus(tbl[4]);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkVal("mid-stall reset out_valid", 64'(out_valid), 64'd0);
    checkVal("mid-stall reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #1;
    checkVal("mid-stall reset out_valid next cycle", 64'(out_valid), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;

    $display("[TB] beats after reset");
    applyStimulus(tbl[0]);
    applyStimulus(tbl[6]);
    waitDrain("drain post-reset");
    repeat (3) @(posedge clk);
    #1;
    checkVal("idle out_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
